// File: rtl/stack_seq.sv
// stack_seq: multi-cycle stack push/pull/call/return engine that owns the stack pointer.
// Define STACK_GUARD_EN to suppress memory accesses that would wrap the stack pointer.
module stack_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int SP_W = 8,
    parameter logic [ADDR_W-1:0] STACK_BASE = 16'h0100,
    parameter logic [SP_W-1:0] SP_RESET = 8'hFF
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [2:0]        CMD,
    input  logic [ADDR_W-1:0] WDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DOUT,
    output logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_DIN,
    output logic [ADDR_W-1:0] RESULT,
    output logic              RES_VALID,
    output logic [SP_W-1:0]   SP,
    output logic              OVF,
    output logic              UNF
);
    localparam int NB = ADDR_W / DATA_W;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam logic [2:0] C_PUSH = 3'd0, C_PULL = 3'd1, C_CALL = 3'd2, C_RET = 3'd3, C_SPLD = 3'd4;
    typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, DONE} state_t;
    state_t state;
    logic [2:0] cmd_q;
    logic [ADDR_W-1:0] wdata_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic blk;
    logic multi;
    logic sp_zero;
    logic sp_ones;
    logic wr_blk;
    logic rd_blk;
    logic [SP_W-1:0] off;
    logic [DATA_W-1:0] rbyte;
    assign multi = cmd_q == C_CALL || cmd_q == C_RET;
    assign sp_zero = SP == '0;
    assign sp_ones = &SP;
    assign wr_blk = GUARD && sp_zero;
    assign rd_blk = GUARD && sp_ones;
    // CALL emits the most-significant byte first so RET can rebuild LSB-first
    assign idx = cmd_q == C_CALL ? LAST - cnt : '0;
    assign rbyte = blk ? '0 : MEM_DIN;
    assign off = state == RD_A ? SP + 1'b1 : SP;
    assign CMD_READY = state == IDLE;
    assign RES_VALID = state == DONE;
    assign MEM_WE = state == WR && !wr_blk;
    assign MEM_DOUT = wdata_q[idx*DATA_W +: DATA_W];
    assign MEM_ADDR = STACK_BASE | ADDR_W'(off);
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state <= IDLE;
            SP <= SP_RESET;
            RESULT <= '0;
            OVF <= 1'b0;
            UNF <= 1'b0;
            cmd_q <= '0;
            wdata_q <= '0;
            cnt <= '0;
            blk <= 1'b0;
        end else begin
            case (state)
                IDLE: if (CMD_VALID) begin
                    cmd_q <= CMD;
                    wdata_q <= WDATA;
                    cnt <= '0;
                    state <= CMD == C_PUSH || CMD == C_CALL ? WR :
                             CMD == C_PULL || CMD == C_RET ? RD_A : DONE;
                    if (CMD == C_SPLD) begin
                        SP <= WDATA[SP_W-1:0];
                        OVF <= 1'b0;
                        UNF <= 1'b0;
                    end
                end
                WR: begin
                    if (sp_zero) OVF <= 1'b1;
                    if (!wr_blk) SP <= SP - 1'b1;
                    cnt <= cnt + 1'b1;
                    if (!multi || cnt == LAST) state <= DONE;
                end
                RD_A: begin
                    if (sp_ones) UNF <= 1'b1;
                    if (!rd_blk) SP <= SP + 1'b1;
                    blk <= rd_blk;
                    state <= RD_D;
                end
                RD_D: begin
                    if (cnt == '0) RESULT <= ADDR_W'(rbyte);
                    else RESULT[cnt*DATA_W +: DATA_W] <= rbyte;
                    cnt <= cnt + 1'b1;
                    state <= !multi || cnt == LAST ? DONE : RD_A;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Parametrised multi-cycle stack engine for the CPU core.
- Executes push, pull, call-push and return-pull sequences on the shared memory bus for PHA/PLA/PHP/PLP/JSR/RTS/BRK/RTI-class instructions.
- Generalises stack access to any DATA_W, ADDR_W and stack page, with multi-byte frames.
- Owns the stack pointer. The CPU sequencer issues one command, then waits for RES_VALID.

Parameters:
- DATA_W, 8: memory data width.
- ADDR_W, 16: memory address width; must be an integer multiple of DATA_W. NBYTES = ADDR_W/DATA_W (default 2).
- SP_W, 8: stack pointer width, SP_W <= ADDR_W.
- STACK_BASE, 16'h0100: stack page base; its low SP_W bits must be zero.
- SP_RESET, 8'hFF: SP value after reset.

Ports:
- CLK  in  1  clock, rising edge.
- R  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD  in  3  command: 000 PUSH, 001 PULL, 010 CALL, 011 RET, 100 SPLD; 101/110/111 NOP.
- WDATA  in  ADDR_W  operand, sampled at accept. PUSH uses [DATA_W-1:0]; SPLD uses [SP_W-1:0].
- MEM_ADDR  out  ADDR_W  STACK_BASE | zero-extended SP-derived offset.
- MEM_DOUT  out  DATA_W  write data.
- MEM_WE  out  1  write strobe.
- MEM_DIN  in  DATA_W  read data, valid the cycle after its address is presented.
- RESULT  out  ADDR_W  pulled value, zero-extended.
- RES_VALID  out  1  one-cycle completion pulse.
- SP  out  SP_W  current stack pointer.
- OVF  out  1  sticky push-wrap flag.
- UNF  out  1  sticky pull-wrap flag.

Behaviour:
- Reset (R low, asynchronous):
  - State is IDLE; SP = SP_RESET.
  - RESULT = 0; OVF = UNF = 0; MEM_WE = RES_VALID = 0.
  - Any in-flight sequence is aborted; no partial write completes after R falls.
- Accept: CMD_VALID && CMD_READY at a rising edge latches CMD and WDATA. CMD_READY is low from the next cycle until RES_VALID has pulsed.
- States: IDLE, WR, RD_A, RD_D, DONE. A byte counter runs 0..NBYTES-1.
- PUSH:
  - IDLE -> WR (1 cycle): MEM_WE = 1, MEM_ADDR = BASE|SP, MEM_DOUT = WDATA low byte.
  - SP <= SP-1 at the end of WR.
  - WR -> DONE, then IDLE. Latency from accept to RES_VALID is 2 cycles.
- CALL:
  - NBYTES consecutive WR cycles, pushing the most-significant byte first.
  - SP decrements each cycle, then DONE.
- PULL:
  - RD_A: MEM_ADDR = BASE|(SP+1); SP <= SP+1.
  - RD_D: RESULT[DATA_W-1:0] <= MEM_DIN; upper RESULT bits cleared.
  - Then DONE. Latency 3 cycles.
- RET:
  - NBYTES pairs of RD_A/RD_D, least-significant byte first, so it returns exactly what CALL pushed.
  - Then DONE. Latency 2*NBYTES+1 cycles.
- SPLD: SP <= WDATA[SP_W-1:0]; OVF and UNF cleared; IDLE -> DONE. Latency 1 cycle.
- NOP codes: IDLE -> DONE with RESULT unchanged.
- DONE: RES_VALID = 1 for exactly one cycle. RESULT holds its value until the next PULL/RET capture.
- Arithmetic: SP increment and decrement are modulo 2^SP_W.
  - A PUSH/CALL byte written at SP == 0 sets OVF.
  - A PULL/RET byte read with SP == all-ones sets UNF.
  - Flags stay set until SPLD or reset.
- MEM_WE is asserted only in WR. MEM_ADDR in non-access states is BASE|SP.
- CMD_VALID while busy is ignored, with no queuing.
- An SPLD accepted immediately after a PUSH sees the post-decrement SP, since commands are strictly serialised.

Optional Feature:
- STACK_GUARD_EN defined:
  - A push byte at SP == 0, or a pull byte at SP == all-ones, performs no memory access.
  - For a blocked pull byte, the captured byte is 0.
  - SP is unchanged for that byte, the flag is set, and the sequence still runs to DONE with normal latency.
- STACK_GUARD_EN undefined: SP wraps and the access is performed; the flag is still set.

Test Plan:
- Reset, then PUSH WDATA=16'h00A5 -> WR cycle with MEM_ADDR=16'h01FF, MEM_DOUT=8'hA5, MEM_WE=1; then SP=8'hFE and RES_VALID 2 cycles after accept.
- CALL WDATA=16'h1234 from SP=8'hFF -> writes 8'h12 at 16'h01FF, then 8'h34 at 16'h01FE; SP=8'hFD. RET follows -> RESULT=16'h1234, SP=8'hFF, RES_VALID 5 cycles after accept.
- SPLD WDATA=16'h0000, then PUSH 16'h0077 -> write at 16'h0100, SP=8'hFF, OVF=1. With the guard defined: no MEM_WE, SP stays 8'h00.
- SPLD 16'h00FF, then PULL -> read at 16'h0100 (SP wraps to 8'h00), UNF=1. A following SPLD clears OVF/UNF to 0.
- Assert R low during the second WR of a CALL -> MEM_WE drops immediately; after release SP=8'hFF, CMD_READY=1, no RES_VALID.
- CMD_VALID held high with new commands during a RET -> only the first command is accepted; the next is accepted the cycle after RES_VALID.
